switch_out_arbiter: RTL
=======================

Name: switch_out_arbiter

Overview:
- Per-output-port scheduler for the 6-port multicast/reduction switch.
- Each cycle it decides which input owns each of the six direction outputs (XPOS, YPOS, ZPOS, XNEG, YNEG, ZNEG).
- It tracks downstream buffer credits per output, returns a same-cycle accept to the winning inputs, and drives registered grant/select/valid to the switch datapath mux stage.
- It replaces the combinational in_avail back-pressure with round-robin, credit-based flow control.

Parameters:
- PORT_NUM, 6, number of inputs and outputs. Output o serves direction code o+1.
- ROUTE_LEN, 3, width of each per-input direction code and of each select field.
- CREDIT_DEPTH, 4, downstream buffer slots per output. Also the credit reset value.
- CREDIT_W, 3, credit counter width. Must hold CREDIT_DEPTH.

Ports:
- clk  input  1  switch clock.
- rst  input  1  asynchronous, active-low reset.
- route_in  input  PORT_NUM*ROUTE_LEN  direction code per input. Field i = [i*ROUTE_LEN +: ROUTE_LEN]. Codes 1..6 = DIR_XPOS..DIR_ZNEG.
- in_valid  input  PORT_NUM  input i holds a flit.
- in_tail  input  PORT_NUM  flit on input i is last of its packet. Used only with SWITCH_ARB_LOCK_EN.
- credit_return  input  PORT_NUM  one-cycle pulse: downstream of output o freed one slot.
- in_ready  output  PORT_NUM  combinational. Flit on input i is accepted at this clock edge.
- grant  output  PORT_NUM*PORT_NUM  registered. One-hot winning input for output o in [o*PORT_NUM +: PORT_NUM].
- out_sel  output  PORT_NUM*ROUTE_LEN  registered. Binary index of the winner for output o.
- out_valid  output  PORT_NUM  registered. Output o carries a flit this cycle.

Behaviour:
- Request: req[o][i] = in_valid[i] && route_in field i == o+1. Codes 0 and 7 request nothing: in_ready stays 0 and the flit is held, never dropped.
- Each input requests at most one output, so each input wins at most once per cycle.
- Arbitration is combinational per output.
  - Eligible when credit[o] != 0 and req[o] is non-zero.
  - Winner = first requesting input scanning from rr_ptr[o] upward, wrapping PORT_NUM-1 -> 0.
- in_ready[i] = 1 in the same cycle input i wins. Accept = in_valid && in_ready.
- Pipeline: grant, out_sel and out_valid register the arbitration result. Latency is one cycle from accept to out_valid.
  - No winner -> out_valid[o] = 0, grant field 0, out_sel holds its previous value.
- Round-robin: on a win, rr_ptr[o] <= winner+1, wrapping to 0 after PORT_NUM-1. rr_ptr is unchanged when there is no win.
- Credit next-state: credit[o] - win[o] + credit_return[o].
  - Win and return in the same cycle -> unchanged.
  - Return at CREDIT_DEPTH with no win -> saturate at CREDIT_DEPTH.
  - credit[o] == 0 -> no win on output o, regardless of requests. A return at 0 allows a win on the next cycle, not the same cycle.
- Reset (rst low, asynchronous, including mid-packet):
  - grant = 0, out_sel = 0, out_valid = 0.
  - rr_ptr = 0, credit = CREDIT_DEPTH, locks cleared.
  - in_ready forced to 0 while rst is low.
  - Flits in flight downstream are not tracked. Credit returns for them saturate.

Optional Feature:
- SWITCH_ARB_LOCK_EN defined: wormhole packet locking.
  - A win with in_tail[i] = 0 sets lock[o] and lock_owner[o] = i.
  - While locked, only lock_owner may win output o. Its requests still need credit.
  - rr_ptr[o] is frozen while locked.
  - Lock clears at the edge where the owner's tail flit is accepted.
  - A single-flit packet (tail on the first flit) never locks.
  - Locks reset to cleared.
- Not defined: in_tail is ignored and every flit is arbitrated independently. There is no lock state.

Test Plan:
- Single request: after reset, input 2 valid with route 1 -> in_ready = 6'b000100 that cycle. Next cycle out_valid[0] = 1, grant[5:0] = 6'b000100, out_sel[2:0] = 2; credit[0] becomes 3.
- Round-robin: inputs 0, 3 and 5 hold route 2 with credit_return[1] pulsed every cycle -> output 1 winners are 0, 3, 5, 0, 3 on consecutive cycles, with no gaps.
- Credit exhaustion: input 1 holds route 3 with no returns -> exactly 4 accepts, then in_ready[1] = 0 indefinitely. One credit_return[2] pulse -> exactly one more accept on the following cycle.
- Boundaries:
  - Credit 2 with a simultaneous win and return -> stays 2.
  - Return at 4 -> stays 4.
  - Input 4 with route 0 or route 7 and valid -> in_ready[4] = 0, out_valid = 0.
- Async reset: assert rst low mid-stream between clock edges -> grant, out_valid and in_ready go 0 immediately. After release, credits are 4 and the first winner is the lowest requesting index.
- Lock (SWITCH_ARB_LOCK_EN): input 4 sends 3 flits on route 6 (tail only on the 3rd) while input 0 also requests route 6 -> output 5 grants input 4 three times, then input 0. Without the macro -> grants alternate 4, 0, 4, 0.

Source files
------------

// File: rtl/switch_out_arbiter_if.sv
// Handshake/bus bundle between the switch input stage and the per-output arbiter.
// master drives requests and credit returns; slave (the arbiter) drives accepts and mux controls.
interface switch_out_arbiter_if #(
   parameter int PORT_NUM  = 6,
   parameter int ROUTE_LEN = 3
);
   logic [PORT_NUM*ROUTE_LEN-1:0] route_in;
   logic [PORT_NUM-1:0]           in_valid;
   logic [PORT_NUM-1:0]           in_tail;
   logic [PORT_NUM-1:0]           credit_return;
   logic [PORT_NUM-1:0]           in_ready;
   logic [PORT_NUM*PORT_NUM-1:0]  grant;
   logic [PORT_NUM*ROUTE_LEN-1:0] out_sel;
   logic [PORT_NUM-1:0]           out_valid;

   modport master (
      output route_in, in_valid, in_tail, credit_return,
      input  in_ready, grant, out_sel, out_valid
   );

   modport slave (
      input  route_in, in_valid, in_tail, credit_return,
      output in_ready, grant, out_sel, out_valid
   );
endinterface

// File: rtl/switch_out_arbiter.sv
// Per-output round-robin, credit-based scheduler for the 6-port switch.
// Define SWITCH_ARB_LOCK_EN to hold an output for a whole wormhole packet until its tail flit.
module switch_out_arbiter #(
   parameter int PORT_NUM     = 6,
   parameter int ROUTE_LEN    = 3,
   parameter int CREDIT_DEPTH = 4,
   parameter int CREDIT_W     = 3
) (
   input logic                 clk,
   input logic                 rst,
   switch_out_arbiter_if.slave bus
);
   typedef logic [ROUTE_LEN-1:0] idx_t;
   typedef logic [CREDIT_W-1:0]  credit_t;

   localparam credit_t CREDIT_MAX = credit_t'(CREDIT_DEPTH);
   localparam idx_t    LAST_IDX   = idx_t'(PORT_NUM - 1);

   credit_t [PORT_NUM-1:0]              credit_q, credit_d;
   idx_t    [PORT_NUM-1:0]              rr_ptr_q, rr_ptr_d;
   logic    [PORT_NUM-1:0][PORT_NUM-1:0] grant_q, grant_d;
   idx_t    [PORT_NUM-1:0]              out_sel_q, out_sel_d;
   logic    [PORT_NUM-1:0]              out_valid_q, out_valid_d;

   logic    [PORT_NUM-1:0][PORT_NUM-1:0] req;
   logic    [PORT_NUM-1:0]              win;
   idx_t    [PORT_NUM-1:0]              winner;
   logic    [PORT_NUM-1:0]              ready;

`ifdef SWITCH_ARB_LOCK_EN
   logic [PORT_NUM-1:0] lock_q, lock_d;
   idx_t [PORT_NUM-1:0] lock_owner_q, lock_owner_d;
`else
   logic unused_tail;
   assign unused_tail = ^bus.in_tail;
`endif

   // Arbitration: first requester at or after rr_ptr, only while the output holds a credit.
   // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
   always_comb begin
      int idx;
      idx    = 0;
      req    = '0;
      win    = '0;
      winner = '0;
      ready  = '0;
      for (int o = 0; o < PORT_NUM; o++) begin
         for (int i = 0; i < PORT_NUM; i++) begin
            req[o][i] = bus.in_valid[i] &&
                        (bus.route_in[i*ROUTE_LEN +: ROUTE_LEN] == idx_t'(o + 1));
`ifdef SWITCH_ARB_LOCK_EN
            if (lock_q[o] && (idx_t'(i) != lock_owner_q[o])) req[o][i] = 1'b0;
`endif
         end
         if (credit_q[o] != '0) begin
            for (int k = 0; k < PORT_NUM; k++) begin
               idx = int'(rr_ptr_q[o]) + k;
               if (idx >= PORT_NUM) idx = idx - PORT_NUM;
               if (!win[o] && req[o][idx]) begin
                  win[o]     = 1'b1;
                  winner[o]  = idx_t'(idx);
                  ready[idx] = 1'b1;
               end
            end
         end
      end
   end

   assign bus.in_ready = rst ? ready : '0;

   always_comb begin
      credit_d    = credit_q;
      rr_ptr_d    = rr_ptr_q;
      grant_d     = '0;
      out_sel_d   = out_sel_q;
      out_valid_d = win;
`ifdef SWITCH_ARB_LOCK_EN
      lock_d       = lock_q;
      lock_owner_d = lock_owner_q;
`endif
      for (int o = 0; o < PORT_NUM; o++) begin
         // A win is only possible with credit left, so the decrement cannot underflow.
         if (win[o] && !bus.credit_return[o]) begin
            credit_d[o] = credit_q[o] - credit_t'(1);
         end else if (!win[o] && bus.credit_return[o] && (credit_q[o] != CREDIT_MAX)) begin
            credit_d[o] = credit_q[o] + credit_t'(1);
         end

         if (win[o]) begin
            grant_d[o][winner[o]] = 1'b1;
            out_sel_d[o]          = winner[o];
`ifdef SWITCH_ARB_LOCK_EN
            if (!lock_q[o]) begin
               rr_ptr_d[o] = (winner[o] == LAST_IDX) ? '0 : winner[o] + idx_t'(1);
               if (!bus.in_tail[winner[o]]) begin
                  lock_d[o]       = 1'b1;
                  lock_owner_d[o] = winner[o];
               end
            end else if (bus.in_tail[winner[o]]) begin
               lock_d[o] = 1'b0;
            end
`else
            rr_ptr_d[o] = (winner[o] == LAST_IDX) ? '0 : winner[o] + idx_t'(1);
`endif
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         credit_q    <= {PORT_NUM{CREDIT_MAX}};
         rr_ptr_q    <= '0;
         grant_q     <= '0;
         out_sel_q   <= '0;
         out_valid_q <= '0;
`ifdef SWITCH_ARB_LOCK_EN
         lock_q       <= '0;
         lock_owner_q <= '0;
`endif
      end else begin
         credit_q    <= credit_d;
         rr_ptr_q    <= rr_ptr_d;
         grant_q     <= grant_d;
         out_sel_q   <= out_sel_d;
         out_valid_q <= out_valid_d;
`ifdef SWITCH_ARB_LOCK_EN
         lock_q       <= lock_d;
         lock_owner_q <= lock_owner_d;
`endif
      end
   end

   assign bus.grant     = grant_q;
   assign bus.out_sel   = out_sel_q;
   assign bus.out_valid = out_valid_q;
endmodule
